phase_sched: RTL and testbench

PHASE_SCHED -- requirements
Module: phase_sched

---
 rtl/phase_sched_pkg.sv | 27 ++
 rtl/phase_sched_timer.sv | 25 ++
 rtl/phase_sched.sv | 131 +++++++++++++
 tb/tb_phase_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/phase_sched_pkg.sv
// Shared state encoding and PHASE output codes for the phase scheduler.
package phase_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GREEN_A = 3'd1,
    ST_GREEN_B = 3'd2,
    ST_AMBER_A = 3'd3,
    ST_AMBER_B = 3'd4,
    ST_CLEAR   = 3'd5
  } state_t;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_GREEN = 2'd1;
  localparam logic [1:0] PH_AMBER = 2'd2;
  localparam logic [1:0] PH_CLEAR = 2'd3;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_GREEN_A, ST_GREEN_B: phase_of = PH_GREEN;
      ST_AMBER_A, ST_AMBER_B: phase_of = PH_AMBER;
      ST_CLEAR:               phase_of = PH_CLEAR;
      default:                phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/phase_sched_timer.sv
// Phase timer: CW-bit counter with clear, tick and hold; tc flags the expiring tick.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          tick,
  input  logic          hold,
  input  logic [CW-1:0] dur,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (tick && !hold)
      cnt <= cnt + 1'b1;
  end

  // High only on the edge that completes the DUR-th effective tick
  assign tc = tick && !hold && (cnt == dur - 1'b1);

endmodule

// File: rtl/phase_sched.sv
// Two-requester round-robin phase scheduler (IDLE -> GREEN -> AMBER -> CLEAR).
// Optional green extension compiled in with PHASE_SCHED_EXTEND_EN.
module phase_sched
  import phase_sched_pkg::*;
#(
  parameter int GREEN_T = 8,
  parameter int AMBER_T = 3,
  parameter int CLEAR_T = 2,
  parameter int CW      = 4,
  parameter int MAX_EXT = 2
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       HOLD,
  input  logic       REQ_A,
  input  logic       REQ_B,
  output logic       GRANT_A,
  output logic       GRANT_B,
  output logic [1:0] PHASE,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [CW-1:0] GREEN_D = CW'(GREEN_T);
  localparam logic [CW-1:0] AMBER_D = CW'(AMBER_T);
  localparam logic [CW-1:0] CLEAR_D = CW'(CLEAR_T);

  state_t        state, nxt;
  logic          last_b;
  logic          win_b;
  logic          tc;
  logic          clr;
  logic          restart;
  logic          ext_a, ext_b;
  logic [CW-1:0] dur;

  // A lone request wins; on a tie the side not served last wins
  assign win_b = REQ_B && (!REQ_A || !last_b);

`ifdef PHASE_SCHED_EXTEND_EN
  localparam int EW = $clog2(MAX_EXT + 2);
  localparam logic [EW-1:0] EXT_MAX = EW'(MAX_EXT);
  logic [EW-1:0] ext_cnt;

  assign ext_a = REQ_A && !REQ_B && (ext_cnt < EXT_MAX);
  assign ext_b = REQ_B && !REQ_A && (ext_cnt < EXT_MAX);

  always_ff @(posedge CK) begin
    if (RST)
      ext_cnt <= '0;
    else if (state == ST_IDLE && nxt != ST_IDLE)
      ext_cnt <= '0;
    else if (restart)
      ext_cnt <= ext_cnt + 1'b1;
  end
`else
  // MAX_EXT only matters when extension is compiled in
  logic unused_max_ext;
  assign unused_max_ext = (MAX_EXT != 0);
  assign ext_a = 1'b0;
  assign ext_b = 1'b0;
`endif

  always_comb begin
    case (state)
      ST_GREEN_A, ST_GREEN_B: dur = GREEN_D;
      ST_AMBER_A, ST_AMBER_B: dur = AMBER_D;
      default:                dur = CLEAR_D;
    endcase
  end

  always_comb begin
    nxt     = state;
    restart = 1'b0;
    case (state)
      ST_IDLE:
        if (REQ_A || REQ_B) nxt = win_b ? ST_GREEN_B : ST_GREEN_A;
      ST_GREEN_A:
        if (tc) begin
          if (ext_a) restart = 1'b1;
          else       nxt = ST_AMBER_A;
        end
      ST_GREEN_B:
        if (tc) begin
          if (ext_b) restart = 1'b1;
          else       nxt = ST_AMBER_B;
        end
      ST_AMBER_A, ST_AMBER_B:
        if (tc) nxt = ST_CLEAR;
      ST_CLEAR:
        if (tc) nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  assign clr = RST || restart || (state == ST_IDLE) || (nxt != state);

  phase_timer #(.CW(CW)) u_timer (
    .clk  (CK),
    .clr  (clr),
    .tick (TICK),
    .hold (HOLD),
    .dur  (dur),
    .tc   (tc)
  );

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= ST_IDLE;
      PHASE   <= PH_IDLE;
      GRANT_A <= 1'b0;
      GRANT_B <= 1'b0;
      DONE    <= 1'b0;
      last_b  <= 1'b1;
    end else begin
      state   <= nxt;
      PHASE   <= phase_of(nxt);
      GRANT_A <= (nxt == ST_GREEN_A) || (nxt == ST_AMBER_A);
      GRANT_B <= (nxt == ST_GREEN_B) || (nxt == ST_AMBER_B);
      DONE    <= (state == ST_CLEAR) && (nxt == ST_IDLE);
      if (state == ST_IDLE && nxt != ST_IDLE)
        last_b <= (nxt == ST_GREEN_B);
    end
  end

  assign BUSY = (PHASE != PH_IDLE);

endmodule

// File: tb/tb_phase_sched.sv
// Scoreboard bench for phase_sched: expected per-cycle outputs queued, then drained against the DUT.
module tb_phase_sched;

  logic       CK = 1'b0;
  logic       RST, TICK, HOLD, REQ_A, REQ_B;
  logic       GRANT_A, GRANT_B, BUSY, DONE;
  logic [1:0] PHASE;

  phase_sched dut (
    .CK(CK), .RST(RST), .TICK(TICK), .HOLD(HOLD), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GRANT_A(GRANT_A), .GRANT_B(GRANT_B), .PHASE(PHASE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e;
  int k, hold_from, hold_len, tick_per, ra_len, rb_len;

  // {phase, grant_a, grant_b, busy, done}
  function automatic void expect_n(input logic [1:0] ph, input logic ga, input logic gb,
                                   input logic dn, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ph, ga, gb, (ph != 2'd0), dn});
  endfunction

  function automatic logic [5:0] obs();
    return {PHASE, GRANT_A, GRANT_B, BUSY, DONE};
  endfunction

  task automatic setup(input int hf, input int hl, input int tp, input int ra, input int rb);
    hold_from = hf; hold_len = hl; tick_per = tp; ra_len = ra; rb_len = rb; k = 0;
  endtask

  // Drive inputs for the coming edge, then land 1 time unit after it
  task automatic step();
    HOLD  = (k >= hold_from) && (k < hold_from + hold_len);
    TICK  = (k % tick_per) == 0;
    REQ_A = (ra_len < 0) || (k < ra_len);
    REQ_B = (rb_len < 0) || (k < rb_len);
    @(posedge CK); #1;
    k++;
  endtask

  task automatic hard_reset();
    REQ_A = 1'b0; REQ_B = 1'b0; TICK = 1'b1; HOLD = 1'b0; RST = 1'b1;
    repeat (2) @(posedge CK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    setup(0, 0, 1, -1, -1);
    RST = 1'b1;
    expect_n(2'd0, 0, 0, 0, 2);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL reset cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_single_pulse();
    hard_reset();
    setup(0, 0, 1, 1, 0);
    expect_n(2'd1, 1, 0, 0, 8); expect_n(2'd2, 1, 0, 0, 3);
    expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1); expect_n(2'd0, 0, 0, 0, 2);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL single_pulse cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_round_robin();
    hard_reset();
    setup(0, 0, 1, -1, -1);
    expect_n(2'd1, 1, 0, 0, 8); expect_n(2'd2, 1, 0, 0, 3); expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    expect_n(2'd1, 0, 1, 0, 8); expect_n(2'd2, 0, 1, 0, 3); expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    expect_n(2'd1, 1, 0, 0, 8); expect_n(2'd2, 1, 0, 0, 3); expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e || (GRANT_A && GRANT_B)) begin
        errors++; $display("FAIL round_robin cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_hold();
    hard_reset();
    setup(2, 5, 1, 1, 0);
    expect_n(2'd1, 1, 0, 0, 13); expect_n(2'd2, 1, 0, 0, 3);
    expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL hold cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_slow_tick();
    hard_reset();
    setup(0, 0, 4, 1, 0);
    expect_n(2'd1, 1, 0, 0, 32); expect_n(2'd2, 1, 0, 0, 12);
    expect_n(2'd3, 0, 0, 0, 8); expect_n(2'd0, 0, 0, 1, 1); expect_n(2'd0, 0, 0, 0, 1);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL slow_tick cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_extension();
    int green;
`ifdef PHASE_SCHED_EXTEND_EN
    green = 24;
`else
    green = 8;
`endif
    hard_reset();
    setup(0, 0, 1, -1, 0);
    expect_n(2'd1, 1, 0, 0, green); expect_n(2'd2, 1, 0, 0, 3);
    expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL extension cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    hard_reset();
    setup(0, 0, 1, -1, 0);
    expect_n(2'd1, 1, 0, 0, 4);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL mid_reset_pre cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
    // Reset with both requests high: RST must dominate
    setup(0, 0, 1, -1, -1);
    RST = 1'b1;
    expect_n(2'd0, 0, 0, 0, 2);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL mid_reset_rst cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
    RST = 1'b0;
    setup(0, 0, 1, -1, -1);
    expect_n(2'd1, 1, 0, 0, 8); expect_n(2'd2, 1, 0, 0, 3); expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    expect_n(2'd1, 0, 1, 0, 8); expect_n(2'd2, 0, 1, 0, 3); expect_n(2'd3, 0, 0, 0, 2); expect_n(2'd0, 0, 0, 1, 1);
    while (exp_q.size() != 0) begin
      step(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL mid_reset_post cyc=%0d got=%b want=%b", k, obs(), e);
      end
    end
  endtask

  initial begin
    RST = 1'b1; TICK = 1'b0; HOLD = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
    test_reset();
    test_single_pulse();
    test_round_robin();
    test_hold();
    test_slow_tick();
    test_extension();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
